// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped branch target buffer with saturating direction counters
// Lookup is combinational against the current array; training lands on the next rising edge.
module branch_predictor #(
  parameter int ENTRIES  = 16,
  parameter int CNT_BITS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] lookup_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        update_en,
  input  logic [31:0] update_pc,
  input  logic        update_taken,
  input  logic [31:0] update_target,
  input  logic        flush_all
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  localparam logic [CNT_BITS-1:0] CNT_MAX  = {CNT_BITS{1'b1}};
  localparam logic [CNT_BITS-1:0] CNT_ZERO = '0;
  localparam logic [CNT_BITS-1:0] CNT_WT   = CNT_BITS'(1) << (CNT_BITS - 1);
  localparam logic [CNT_BITS-1:0] CNT_WNT  = CNT_WT - CNT_BITS'(1);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [29:0]        tgt_q [ENTRIES];
  logic [CNT_BITS-1:0] cnt_q [ENTRIES];

  logic [IDX_W-1:0] l_idx;
  logic [TAG_W-1:0] l_tag;
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;

  // Low address bits of update inputs are never stored.
  logic unused_low_bits;
  assign unused_low_bits = ^{update_pc[1:0], update_target[1:0]};

  assign l_idx = lookup_pc[IDX_W+1:2];
  assign l_tag = lookup_pc[31:IDX_W+2];
  assign u_idx = update_pc[IDX_W+1:2];
  assign u_tag = update_pc[31:IDX_W+2];

  assign pred_hit    = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign pred_taken  = pred_hit && cnt_q[l_idx][CNT_BITS-1];
  assign pred_target = pred_taken ? {tgt_q[l_idx], 2'b00} : lookup_pc + 32'd4;

  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        cnt_q[i] <= CNT_WNT;
      end
    end else if (flush_all) begin
      valid_q <= '0;
    end else if (update_en) begin
      if (u_hit) begin
        if (update_taken) begin
          tgt_q[u_idx] <= update_target[31:2];
          if (cnt_q[u_idx] != CNT_MAX) cnt_q[u_idx] <= cnt_q[u_idx] + CNT_BITS'(1);
        end else if (cnt_q[u_idx] != CNT_ZERO) begin
          cnt_q[u_idx] <= cnt_q[u_idx] - CNT_BITS'(1);
        end
      end else if (update_taken) begin
        // Miss-taken evicts whatever lives at this index; miss-not-taken leaves it alone.
        valid_q[u_idx] <= 1'b1;
        tag_q[u_idx]   <= u_tag;
        tgt_q[u_idx]   <= update_target[31:2];
        cnt_q[u_idx]   <= CNT_WT;
      end
    end
  end

endmodule
